// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input mapper.
package arcade_input_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // ps2_key layout: {toggle, pressed, code[8:0]}
  localparam int unsigned KEY_W           = 11;
  localparam int unsigned CODE_W          = 9;
  localparam int unsigned KEY_TOGGLE_BIT  = 10;
  localparam int unsigned KEY_PRESSED_BIT = 9;

  localparam int unsigned JOY_IDX_W = 5;
  localparam logic [JOY_IDX_W-1:0] JOY_NONE = 5'h1F;

  typedef struct packed {
    logic              pressed;
    logic [CODE_W-1:0] code;
  } key_evt_t;

  // Extract the press/code payload from a raw ps2_key word.
  function automatic key_evt_t key_evt(input logic [KEY_W-1:0] key);
    key_evt_t e;
    e.pressed = key[KEY_PRESSED_BIT];
    e.code    = key[CODE_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// Holds a button asserted for at least PULSE_CYC clocks after each rising edge.
module input_pulse_stretch #(
  parameter int unsigned PULSE_CYC = 250000,
  localparam int unsigned CW = (PULSE_CYC > 0) ? $clog2(PULSE_CYC + 1) : 1
) (
  input  logic clk_sys,
  input  logic RESET_n,
  input  logic raw,
  output logic level_c
);

  logic          raw_q;
  logic [CW-1:0] cnt_q;

  // Reload on every rising edge of raw, otherwise count down to zero.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      raw_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw;
      if (raw && !raw_q) begin
        cnt_q <= CW'(PULSE_CYC);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign level_c = raw | (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events through a programmable table onto arcade buttons,
// merged with joystick bits, optionally stretched, then registered out.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_BTN   = 8,
  parameter int unsigned MAP_DEPTH = 16,
  parameter int unsigned JOY_W     = 16,
  parameter logic [NUM_BTN*JOY_IDX_W-1:0] JOY_IDX = {NUM_BTN{JOY_NONE}},
  parameter logic [NUM_BTN-1:0] TOGGLE_MASK = '0,
  parameter logic [NUM_BTN-1:0] PULSE_MASK  = '0,
  parameter int unsigned PULSE_CYC = 250000,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int unsigned AW = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1,
  localparam int unsigned BW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk_sys,
  input  logic               RESET_n,
  input  logic [KEY_W-1:0]   ps2_key,
  input  logic [JOY_W-1:0]   joy_0,
  input  logic [JOY_W-1:0]   joy_1,
  input  logic               map_wr,
  input  logic [AW-1:0]      map_addr,
  input  logic               map_valid,
  input  logic [CODE_W-1:0]  map_code,
  input  logic [BW-1:0]      map_btn,
  input  logic               ovf_clr,
  output logic [NUM_BTN-1:0] btn_out,
  output logic [NUM_BTN-1:0] key_state,
  output logic               busy,
  output logic               overflow
);

  scan_state_e        state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  key_evt_t           cur_q, cur_d;
  key_evt_t           pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic               overflow_d;
  logic [NUM_BTN-1:0] key_state_d;
  logic               armed_q, tog_q;
  logic               event_c, hit_c, last_c, ovf_set_c;

  logic               map_valid_q [MAP_DEPTH];
  logic [CODE_W-1:0]  map_code_q  [MAP_DEPTH];
  logic [BW-1:0]      map_btn_q   [MAP_DEPTH];

  logic [JOY_W-1:0]   joy0_q, joy1_q;
  logic [NUM_BTN-1:0] raw_c, stretched_c;

  // Track the toggle bit; the first clock after reset only primes the copy.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      armed_q <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      tog_q   <= ps2_key[KEY_TOGGLE_BIT];
    end
  end

  assign event_c = armed_q & (ps2_key[KEY_TOGGLE_BIT] ^ tog_q);

  // Key map table; a write lands at the edge, so the scan reads the old entry.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        map_valid_q[i] <= 1'b0;
        map_code_q[i]  <= '0;
        map_btn_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        if (map_wr && (map_addr == AW'(i))) begin
          map_valid_q[i] <= map_valid;
          map_code_q[i]  <= map_code;
          map_btn_q[i]   <= map_btn;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan datapath registers and registered status outputs.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      idx_q        <= '0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      key_state    <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      key_state    <= key_state_d;
      overflow     <= overflow_d;
      busy         <= (state_d == ST_SCAN);
    end
  end

  // Next-state, scan sequencing, pending buffer and button updates.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    key_state_d  = key_state;
    ovf_set_c    = 1'b0;
    hit_c        = map_valid_q[idx_q] && (map_code_q[idx_q] == cur_q.code);
    last_c       = (idx_q == AW'(MAP_DEPTH - 1));

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          state_d      = ST_SCAN;
          idx_d        = '0;
          cur_d        = pend_q;
          pend_valid_d = 1'b0;
          ovf_set_c    = event_c;
        end else if (event_c) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cur_d   = key_evt(ps2_key);
        end
      end

      ST_SCAN: begin
        if (hit_c) begin
          for (int b = 0; b < NUM_BTN; b++) begin
            if (map_btn_q[idx_q] == BW'(b)) begin
              if (TOGGLE_MASK[b]) begin
                key_state_d[b] = key_state[b] ^ cur_q.pressed;
              end else begin
                key_state_d[b] = cur_q.pressed;
              end
            end
          end
        end

        if (event_c) begin
          if (pend_valid_q) begin
            ovf_set_c = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_d       = key_evt(ps2_key);
          end
        end

        if (last_c) begin
          if (pend_valid_q) begin
            idx_d        = '0;
            cur_d        = pend_q;
            pend_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    overflow_d = (overflow & ~ovf_clr) | ovf_set_c;
  end

  // Joystick inputs registered once before merging.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      joy0_q <= '0;
      joy1_q <= '0;
    end else begin
      joy0_q <= joy_0;
      joy1_q <= joy_1;
    end
  end

  logic unused_joy_c;
  assign unused_joy_c = ^{joy0_q, joy1_q};

  // Per-button merge of keyboard and joystick, with optional stretch.
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    localparam int unsigned IDX = 32'(JOY_IDX[b*JOY_IDX_W +: JOY_IDX_W]);
    logic joy_c;

    if ((IDX == 32'(JOY_NONE)) || (IDX >= JOY_W)) begin : g_nojoy
      assign joy_c = 1'b0;
    end else begin : g_joy
      assign joy_c = joy0_q[IDX] | joy1_q[IDX];
    end

    assign raw_c[b] = key_state[b] | joy_c;

    if (PULSE_MASK[b]) begin : g_stretch
      input_pulse_stretch #(
        .PULSE_CYC(PULSE_CYC)
      ) u_stretch (
        .clk_sys(clk_sys),
        .RESET_n(RESET_n),
        .raw    (raw_c[b]),
        .level_c(stretched_c[b])
      );
    end else begin : g_pass
      assign stretched_c[b] = raw_c[b];
    end
  end

  // Final registered buttons in the board's polarity.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      btn_out <= {NUM_BTN{ACTIVE_LOW}};
    end else begin
      btn_out <= ACTIVE_LOW ? ~stretched_c : stretched_c;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper with a table-level reference model.
module tb_arcade_input_mapper;

  localparam int unsigned NB = 8;
  localparam int unsigned MD = 16;
  localparam int unsigned JW = 16;
  localparam int unsigned PC = 100;
  // btn5 <- joystick bit 3, btn2 <- joystick bit 7, others unmapped
  localparam logic [NB*5-1:0] JIDX =
    {5'h1F, 5'h1F, 5'h03, 5'h1F, 5'h1F, 5'h07, 5'h1F, 5'h1F};
  localparam logic [NB-1:0] TMASK = 8'h04;
  localparam logic [NB-1:0] PMASK = 8'h04;

  logic          clk_sys;
  logic          RESET_n;
  logic [10:0]   ps2_key;
  logic [JW-1:0] joy_0, joy_1;
  logic          map_wr;
  logic [3:0]    map_addr;
  logic          map_valid;
  logic [8:0]    map_code;
  logic [2:0]    map_btn;
  logic          ovf_clr;
  logic [NB-1:0] btn_out, key_state;
  logic          busy, overflow;

  arcade_input_mapper #(
    .NUM_BTN    (NB),
    .MAP_DEPTH  (MD),
    .JOY_W      (JW),
    .JOY_IDX    (JIDX),
    .TOGGLE_MASK(TMASK),
    .PULSE_MASK (PMASK),
    .PULSE_CYC  (PC),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_sys  (clk_sys),
    .RESET_n  (RESET_n),
    .ps2_key  (ps2_key),
    .joy_0    (joy_0),
    .joy_1    (joy_1),
    .map_wr   (map_wr),
    .map_addr (map_addr),
    .map_valid(map_valid),
    .map_code (map_code),
    .map_btn  (map_btn),
    .ovf_clr  (ovf_clr),
    .btn_out  (btn_out),
    .key_state(key_state),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: key table contents and keyboard button state.
  logic          m_valid [MD];
  logic [8:0]    m_code  [MD];
  int unsigned   m_btn   [MD];
  logic [NB-1:0] m_ks;
  logic          tog;
  logic [8:0]    codes [6] = '{9'h03A, 9'h016, 9'h01C, 9'h16B, 9'h06B, 9'h055};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Every valid entry whose code matches applies to its button.
  task automatic model_apply(input logic pressed, input logic [8:0] code);
    for (int i = 0; i < MD; i++) begin
      if (m_valid[i] && m_code[i] == code) begin
        if (TMASK[m_btn[i]]) begin
          if (pressed) m_ks[m_btn[i]] = ~m_ks[m_btn[i]];
        end else begin
          m_ks[m_btn[i]] = pressed;
        end
      end
    end
  endtask

  function automatic logic [NB-1:0] exp_btn(input logic [NB-1:0] ks,
                                            input logic [JW-1:0] j0,
                                            input logic [JW-1:0] j1);
    logic [NB*5-1:0] jidx;
    logic [NB-1:0]   r;
    int unsigned     ix;
    jidx = JIDX;
    r    = ks;
    for (int b = 0; b < NB; b++) begin
      ix = 32'(jidx[b*5 +: 5]);
      if (ix < JW) r[b] = r[b] | j0[ix] | j1[ix];
    end
    return ~r;
  endfunction

  task automatic wr_map(input int unsigned a, input logic v, input logic [8:0] code,
                        input int unsigned b);
    map_wr    = 1'b1;
    map_addr  = 4'(a);
    map_valid = v;
    map_code  = code;
    map_btn   = 3'(b);
    tick();
    map_wr     = 1'b0;
    m_valid[a] = v;
    m_code[a]  = code;
    m_btn[a]   = b;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code, input bit apply);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
    if (apply) model_apply(pressed, code);
  endtask

  // Wait for the scan to finish, then one more cycle for btn_out.
  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    ps2_key = 11'h400; tog = 1'b1;
    joy_0 = '0; joy_1 = '0;
    map_wr = 1'b0; map_addr = '0; map_valid = 1'b0; map_code = '0; map_btn = '0;
    ovf_clr = 1'b0; RESET_n = 1'b0; m_ks = '0;
    for (int i = 0; i < MD; i++) begin
      m_valid[i] = 1'b0; m_code[i] = '0; m_btn[i] = 0;
    end
    repeat (3) tick();
    chk("rst_btn_out", 32'(btn_out), 32'hFF);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Toggle bit differs from the reset copy: first cycle must not start a scan.
    RESET_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_no_event", 32'(busy), 32'd0);
    end

    // Single mapped key: latency and scan length.
    wr_map(0, 1'b1, 9'h03A, 4);
    wr_map(1, 1'b1, 9'h01C, 6);
    send_key(1'b1, 9'h03A, 1'b1);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy) cnt++;
      if (k == 1) chk("lat_ks_c1", 32'(key_state[4]), 32'd0);
      if (k == 2) chk("lat_ks_c2", 32'(key_state[4]), 32'd1);
      if (k == 2) chk("lat_btn_c2", 32'(btn_out[4]), 32'd1);
      if (k == 3) chk("lat_btn_c3", 32'(btn_out[4]), 32'd0);
    end
    chk("busy_cycles", 32'(cnt), 32'd16);
    chk("press_ks", 32'(key_state), 32'(m_ks));

    send_key(1'b0, 9'h03A, 1'b1);
    wait_idle();
    chk("release_ks", 32'(key_state), 32'(m_ks));
    chk("release_btn", 32'(btn_out), 32'(exp_btn(m_ks, joy_0, joy_1)));

    // Pending buffer and overflow: second event queued, third dropped.
    send_key(1'b1, 9'h03A, 1'b1);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) cnt++;
      if (k == 2) send_key(1'b0, 9'h03A, 1'b1);
      if (k == 4) send_key(1'b1, 9'h01C, 1'b0);
    end
    chk("pend_busy_cycles", 32'(cnt), 32'd32);
    chk("pend_overflow", 32'(overflow), 32'd1);
    chk("pend_ks", 32'(key_state), 32'(m_ks));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Toggle-mode button.
    wr_map(2, 1'b1, 9'h016, 2);
    send_key(1'b1, 9'h016, 1'b1); wait_idle();
    chk("tgl_press1", 32'(key_state[2]), 32'd1);
    send_key(1'b0, 9'h016, 1'b1); wait_idle();
    chk("tgl_release", 32'(key_state[2]), 32'd1);
    send_key(1'b1, 9'h016, 1'b1); wait_idle();
    chk("tgl_press2", 32'(key_state[2]), 32'd0);
    chk("tgl_model", 32'(key_state), 32'(m_ks));

    // Two keys on one button; extended bit must match exactly.
    wr_map(3, 1'b1, 9'h16B, 6);
    wr_map(4, 1'b1, 9'h06B, 7);
    send_key(1'b1, 9'h01C, 1'b1); wait_idle();
    send_key(1'b1, 9'h16B, 1'b1); wait_idle();
    chk("two_keys_held", 32'(key_state[6]), 32'd1);
    send_key(1'b0, 9'h01C, 1'b1); wait_idle();
    chk("two_keys_rel", 32'(key_state[6]), 32'd0);
    chk("ext_code_exact", 32'(key_state[7]), 32'd0);
    send_key(1'b0, 9'h16B, 1'b1); wait_idle();

    // Table writes during a scan: same-cycle entry unaffected, later entry seen.
    send_key(1'b1, 9'h055, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      map_wr = 1'b0;
      if (k == 9) begin
        map_wr = 1'b1; map_addr = 4'd8; map_valid = 1'b1; map_code = 9'h055; map_btn = 3'd1;
      end
      if (k == 10) begin
        map_wr = 1'b1; map_addr = 4'd12; map_valid = 1'b1; map_code = 9'h055; map_btn = 3'd0;
      end
    end
    m_valid[8] = 1'b1; m_code[8] = 9'h055; m_btn[8] = 1;
    m_valid[12] = 1'b1; m_code[12] = 9'h055; m_btn[12] = 0;
    m_ks[0] = 1'b1;
    chk("wr_same_entry", 32'(key_state[1]), 32'd0);
    chk("wr_later_entry", 32'(key_state[0]), 32'd1);
    send_key(1'b0, 9'h055, 1'b1); wait_idle();
    chk("wr_release", 32'(key_state), 32'(m_ks));

    // Joystick path and minimum pulse stretch.
    repeat (120) tick();
    chk("stretch_idle", 32'(btn_out[2]), 32'd1);
    joy_1[3] = 1'b1;
    tick();
    chk("joy_lat_c1", 32'(btn_out[5]), 32'd1);
    tick();
    chk("joy_lat_c2", 32'(btn_out[5]), 32'd0);
    joy_1[3] = 1'b0;
    joy_0[7] = 1'b1;
    tick();
    joy_0[7] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (!btn_out[2]) cnt++;
    end
    chk("stretch_len", 32'((cnt >= 100) && (cnt <= 102)), 32'd1);
    chk("stretch_end", 32'(btn_out[2]), 32'd1);

    // Randomized events and table updates against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        wr_map($urandom_range(0, 15), 1'($urandom_range(0, 3) != 0),
               codes[$urandom_range(0, 5)], $urandom_range(0, 7));
      joy_0 = 16'($urandom) & 16'hFF7F;
      joy_1 = 16'($urandom) & 16'hFF7F;
      send_key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 5)], 1'b1);
      wait_idle();
      chk("rnd_ks", 32'(key_state), 32'(m_ks));
      chk("rnd_btn", 32'(btn_out & 8'hFB), 32'(exp_btn(m_ks, joy_0, joy_1) & 8'hFB));
    end

    // Reset in the middle of a scan.
    joy_0 = '0; joy_1 = '0;
    wr_map(0, 1'b1, 9'h03A, 4);
    repeat (3) tick();
    send_key(1'b1, 9'h03A, 1'b1);
    repeat (5) tick();
    chk("pre_rst_btn4", 32'(btn_out[4]), 32'd0);
    RESET_n = 1'b0;
    #1;
    chk("mid_rst_btn_out", 32'(btn_out), 32'hFF);
    chk("mid_rst_ks", 32'(key_state), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < MD; i++) m_valid[i] = 1'b0;
    m_ks = '0;
    tog = ~tog;
    ps2_key[10] = tog;
    tick();
    RESET_n = 1'b1;
    repeat (3) begin
      tick();
      chk("rst2_no_event", 32'(busy), 32'd0);
    end
    send_key(1'b1, 9'h03A, 1'b1);
    wait_idle();
    chk("rst2_table_invalid", 32'(key_state), 32'(m_ks));
    chk("rst2_btn_out", 32'(btn_out), 32'(exp_btn(m_ks, joy_0, joy_1)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
